// File: rtl/sysobs_probe_arbiter.sv
// sysobs_probe_arbiter: round-robin sharing of one probe register bus among
// several requesters, with busy back-pressure timeout and per-requester responses.
module sysobs_probe_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_W       = 4,
   parameter int DATA_W       = 8,
   parameter int BUSY_TIMEOUT = 16
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic                      rsp_err,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      pr_en,
   output logic                      pr_we,
   output logic [ADDR_W-1:0]         pr_addr,
   output logic [DATA_W-1:0]         pr_wdata,
   input  logic                      pr_busy,
   input  logic [DATA_W-1:0]         pr_rdata
);
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW = $clog2(BUSY_TIMEOUT) + 1;
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2, RESP = 2'd3;

   logic [1:0]         r_state;
   logic [PW-1:0]      r_ptr, r_owner;
   logic [BW-1:0]      r_busy_cnt;
   logic               r_we, r_err;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_wdata, r_rdata;
   logic [NUM_REQ-1:0] w_rot;
   logic [PW-1:0]      w_off, w_win;
   logic [PW:0]        w_sum;
   logic               w_any, w_timeout;

   // Rotate requests so bit 0 is the rr_ptr requester; lowest set bit wins.
   assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_ptr);
   always_comb begin
      w_off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) if (w_rot[k]) w_off = PW'(k);
   end
   assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_win     = (w_sum >= (PW+1)'(NUM_REQ)) ? PW'(w_sum - (PW+1)'(NUM_REQ)) : w_sum[PW-1:0];
   assign w_any     = |req_valid;
   assign w_timeout = (r_busy_cnt == BW'(BUSY_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_owner    <= '0;
         r_busy_cnt <= '0;
         r_we       <= 1'b0;
         r_err      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_any) begin
               r_owner <= w_win;
               r_we    <= req_write[w_win];
               r_addr  <= req_addr[w_win*ADDR_W +: ADDR_W];
               r_wdata <= req_wdata[w_win*DATA_W +: DATA_W];
               r_state <= ISSUE;
            end
            ISSUE: if (!pr_busy) r_state <= r_we ? RESP : WAIT_RD;
            else if (w_timeout) begin
               r_err   <= 1'b1;
               r_state <= RESP;
            end else r_busy_cnt <= r_busy_cnt + BW'(1);
            WAIT_RD: begin
               r_rdata <= pr_rdata;
               r_state <= RESP;
            end
            default: begin
               r_ptr      <= (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + PW'(1);
               r_busy_cnt <= '0;
               r_err      <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = (r_state == IDLE && w_any) ? (NUM_REQ'(1) << w_win) : '0;
   assign rsp_valid = (r_state == RESP) ? (NUM_REQ'(1) << r_owner) : '0;
   assign rsp_err   = (r_state == RESP) & r_err;
   assign rsp_rdata = (r_state == RESP && (r_we || r_err)) ? '0 : r_rdata;
   assign pr_en     = (r_state == ISSUE);
   assign pr_we     = pr_en & r_we;
   assign pr_addr   = pr_en ? r_addr : '0;
   assign pr_wdata  = pr_en ? r_wdata : '0;
endmodule

// File: tb/tb_sysobs_probe_arbiter.sv
// tb_sysobs_probe_arbiter: cycle-by-cycle vector table plus directed
// back-pressure, timeout and mid-transaction reset sequences.
module tb_sysobs_probe_arbiter;
   logic        clk, rst_n;
   logic [3:0]  req_valid, req_write, req_ready, rsp_valid;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_err, pr_en, pr_we, pr_busy;
   logic [7:0]  rsp_rdata, pr_wdata, pr_rdata;
   logic [3:0]  pr_addr;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  v, w;
      logic [15:0] a;
      logic [31:0] d;
      logic        b;
      logic [7:0]  prd;
      logic [30:0] x;
   } vec_t;
   vec_t vecs[$];

   sysobs_probe_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .pr_en(pr_en), .pr_we(pr_we), .pr_addr(pr_addr), .pr_wdata(pr_wdata),
      .pr_busy(pr_busy), .pr_rdata(pr_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [30:0] ex(input logic [3:0] rdy, input logic [3:0] rsp, input logic er,
                                      input logic [7:0] rd, input logic en, input logic we,
                                      input logic [3:0] ad, input logic [7:0] wd);
      return {rdy, rsp, er, rd, en, we, ad, wd};
   endfunction

   function automatic logic [30:0] outs();
      return {req_ready, rsp_valid, rsp_err, rsp_rdata, pr_en, pr_we, pr_addr, pr_wdata};
   endfunction

   task automatic add(input logic [3:0] v, input logic [3:0] w, input logic [15:0] a,
                      input logic [31:0] d, input logic b, input logic [7:0] prd, input logic [30:0] x);
      vecs.push_back('{v, w, a, d, b, prd, x});
   endtask

   task automatic chk(input string nm, input logic [30:0] x);
      #1;
      checks++;
      if (outs() !== x) begin
         errors++;
         $display("FAIL %s: got %h want %h (ready,rsp,err,rdata,en,we,addr,wdata)", nm, outs(), x);
      end
   endtask

   task automatic cyc(input string nm, input logic [30:0] x);
      chk(nm, x);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      pr_busy = 1'b0; pr_rdata = '0;
      // round-robin with all four requesters writing continuously
      add(4'h0, 4'h0, 16'h0000, 32'h0, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 4'h1, 8'h11));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h2, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 4'h2, 8'h22));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h2, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h4, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 4'h3, 8'h33));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h4, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h8, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 4'h4, 8'h44));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h8, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 4'h1, 8'h11));
      add(4'hF, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      // move rr_ptr to 2, then only requesters 1 and 3 pending
      add(4'h2, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h2, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'h0, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 4'h2, 8'h22));
      add(4'h0, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h2, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hA, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h8, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hA, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 4'h4, 8'h44));
      add(4'hA, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h8, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'hA, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h2, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'h0, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 4'h2, 8'h22));
      add(4'h0, 4'hF, 16'h4321, 32'h44332211, 1'b0, 8'h00, ex(4'h0, 4'h2, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'h0, 4'h0, 16'h0000, 32'h0, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      // single write by req 2; inputs change after acceptance
      add(4'h4, 4'h4, 16'h0500, 32'h00A50000, 1'b0, 8'h00, ex(4'h4, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'h0, 4'h0, 16'hFFFF, 32'hFFFFFFFF, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 4'h5, 8'hA5));
      add(4'h0, 4'h0, 16'hFFFF, 32'hFFFFFFFF, 1'b0, 8'h00, ex(4'h0, 4'h4, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'h0, 4'h0, 16'h0000, 32'h0, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      // single read by req 0
      add(4'h1, 4'h0, 16'h0003, 32'h0, 1'b0, 8'h00, ex(4'h1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'h0, 4'h0, 16'h0003, 32'h0, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00));
      add(4'h0, 4'h0, 16'h0003, 32'h0, 1'b0, 8'h3C, ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'h0, 4'h0, 16'h0003, 32'h0, 1'b0, 8'h00, ex(4'h0, 4'h1, 1'b0, 8'h3C, 1'b0, 1'b0, 4'h0, 8'h00));
      add(4'h0, 4'h0, 16'h0000, 32'h0, 1'b0, 8'h00, ex(4'h0, 4'h0, 1'b0, 8'h3C, 1'b0, 1'b0, 4'h0, 8'h00));

      cyc("reset", ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      rst_n = 1'b1;
      foreach (vecs[i]) begin
         req_valid = vecs[i].v; req_write = vecs[i].w; req_addr = vecs[i].a;
         req_wdata = vecs[i].d; pr_busy = vecs[i].b; pr_rdata = vecs[i].prd;
         cyc($sformatf("vec%0d", i), vecs[i].x);
      end

      // back-pressure: 5 busy cycles on a read by req 1
      req_valid = 4'h2; req_write = 4'h0; req_addr = 16'h0090; req_wdata = 32'h0;
      cyc("bp_acc", ex(4'h2, 4'h0, 1'b0, 8'h3C, 1'b0, 1'b0, 4'h0, 8'h00));
      req_valid = 4'h0; req_addr = 16'h0000; pr_busy = 1'b1;
      repeat (5) cyc("bp_hold", ex(4'h0, 4'h0, 1'b0, 8'h3C, 1'b1, 1'b0, 4'h9, 8'h00));
      pr_busy = 1'b0;
      cyc("bp_done", ex(4'h0, 4'h0, 1'b0, 8'h3C, 1'b1, 1'b0, 4'h9, 8'h00));
      pr_rdata = 8'h77;
      cyc("bp_wait", ex(4'h0, 4'h0, 1'b0, 8'h3C, 1'b0, 1'b0, 4'h0, 8'h00));
      pr_rdata = 8'h00;
      cyc("bp_rsp", ex(4'h0, 4'h2, 1'b0, 8'h77, 1'b0, 1'b0, 4'h0, 8'h00));

      // timeout on a read by req 2, then a normal write by req 0
      req_valid = 4'h4; req_addr = 16'h0E00;
      cyc("to_acc", ex(4'h4, 4'h0, 1'b0, 8'h77, 1'b0, 1'b0, 4'h0, 8'h00));
      req_valid = 4'h0; pr_busy = 1'b1;
      repeat (16) cyc("to_hold", ex(4'h0, 4'h0, 1'b0, 8'h77, 1'b1, 1'b0, 4'hE, 8'h00));
      cyc("to_rsp", ex(4'h0, 4'h4, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      pr_busy = 1'b0;
      cyc("to_idle", ex(4'h0, 4'h0, 1'b0, 8'h77, 1'b0, 1'b0, 4'h0, 8'h00));
      req_valid = 4'h1; req_write = 4'h1; req_addr = 16'h0002; req_wdata = 32'h0000005A;
      cyc("to_next_acc", ex(4'h1, 4'h0, 1'b0, 8'h77, 1'b0, 1'b0, 4'h0, 8'h00));
      req_valid = 4'h0;
      cyc("to_next_iss", ex(4'h0, 4'h0, 1'b0, 8'h77, 1'b1, 1'b1, 4'h2, 8'h5A));
      cyc("to_next_rsp", ex(4'h0, 4'h1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));

      // reset while req 1's read sits in WAIT_RD (rr_ptr is 1 here)
      req_valid = 4'h2; req_write = 4'h0; req_addr = 16'h0010; req_wdata = 32'h0;
      cyc("rs_acc", ex(4'h2, 4'h0, 1'b0, 8'h77, 1'b0, 1'b0, 4'h0, 8'h00));
      req_valid = 4'h0;
      cyc("rs_iss", ex(4'h0, 4'h0, 1'b0, 8'h77, 1'b1, 1'b0, 4'h1, 8'h00));
      pr_rdata = 8'h99;
      chk("rs_wait", ex(4'h0, 4'h0, 1'b0, 8'h77, 1'b0, 1'b0, 4'h0, 8'h00));
      rst_n = 1'b0;
      chk("rs_async", ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      @(posedge clk);
      #1;
      rst_n = 1'b1; pr_rdata = 8'h00;
      repeat (3) cyc("rs_quiet", ex(4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));
      req_valid = 4'hF;
      cyc("rs_first", ex(4'h1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
